// File: rtl/game_match_controller.sv
// game_match_controller
//   Sequences a best-of-ROUNDS match on top of the single-round game master.
//   It owns the end-of-game timer and holds the game master in reset between
//   matches. It also samples each round's game_won result and keeps the
//   counters for the score display.
//
// Ports
//   clk                        system clock
//   reset                      asynchronous reset, active low
//   key                        synchronized player key (level)
//   end_of_game_timer_start    one-cycle start pulse from the game master
//   game_won                   registered round result from the game master
//   end_of_game_timer_running  timer busy, fed back to the game master
//   game_hold                  active-high reset to the game master
//   round_count                rounds completed in the current match
//   score_wins                 rounds won
//   score_losses               rounds lost
//   last_round_won             result of the most recently scored round
//   match_over                 match finished, waiting for key
//   match_won                  match result, valid while match_over=1
module game_match_controller #(
  parameter int unsigned TIMER_CYCLES  = 50000000,
  parameter int unsigned ROUNDS        = 5,
  parameter int unsigned WIN_THRESHOLD = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  input  logic       end_of_game_timer_start,
  input  logic       game_won,
  output logic       end_of_game_timer_running,
  output logic       game_hold,
  output logic [3:0] round_count,
  output logic [3:0] score_wins,
  output logic [3:0] score_losses,
  output logic       last_round_won,
  output logic       match_over,
  output logic       match_won
);

  localparam logic [25:0] TIMER_LOAD = 26'(TIMER_CYCLES - 1);
  localparam logic [3:0]  ROUND_MAX  = 4'(ROUNDS);
  localparam logic [3:0]  WIN_LIMIT  = 4'(WIN_THRESHOLD);
  // Once this many rounds are lost, the wins needed can no longer be reached.
  localparam logic [3:0]  LOSS_LIMIT = 4'(ROUNDS - WIN_THRESHOLD + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_SETTLE,
    ST_SCORE,
    ST_MATCH_OVER
  } state_t;

  state_t      state_q, state_d;
  logic        key_prev_q, key_prev_d;
  logic        key_armed_q, key_armed_d;
  logic [25:0] timer_q, timer_d;
  logic        running_q, running_d;
  logic        hold_q, hold_d;
  logic [3:0]  round_count_q, round_count_d;
  logic [3:0]  score_wins_q, score_wins_d;
  logic [3:0]  score_losses_q, score_losses_d;
  logic        last_won_q, last_won_d;
  logic        match_over_q, match_over_d;
  logic        match_won_q, match_won_d;

  logic        key_press;
  logic [3:0]  round_inc;
  logic [3:0]  wins_inc;
  logic [3:0]  losses_inc;
  logic        match_done;

  // The key must be seen low at least once after reset before a rising edge
  // counts. A key held through reset deassertion then cannot start a match.
  assign key_press = key & ~key_prev_q & key_armed_q;

  // Score values after the current round is added; the end-of-match
  // decision is made on these.
  assign round_inc  = round_count_q + 4'd1;
  assign wins_inc   = score_wins_q + {3'b000, last_won_q};
  assign losses_inc = score_losses_q + {3'b000, ~last_won_q};
  assign match_done = (wins_inc == WIN_LIMIT) || (losses_inc == LOSS_LIMIT) ||
                      (round_inc == ROUND_MAX);

  always_comb begin
    state_d        = state_q;
    key_prev_d     = key;
    key_armed_d    = key_armed_q | ~key;
    timer_d        = timer_q;
    running_d      = running_q;
    hold_d         = hold_q;
    round_count_d  = round_count_q;
    score_wins_d   = score_wins_q;
    score_losses_d = score_losses_q;
    last_won_d     = last_won_q;
    match_over_d   = match_over_q;
    match_won_d    = match_won_q;

    unique case (state_q)
      ST_IDLE: begin
        hold_d = 1'b1;
        if (key_press) begin
          round_count_d  = 4'd0;
          score_wins_d   = 4'd0;
          score_losses_d = 4'd0;
          last_won_d     = 1'b0;
          match_won_d    = 1'b0;
          hold_d         = 1'b0;
          state_d        = ST_PLAY;
        end
      end

      ST_PLAY: begin
        hold_d = 1'b0;
        if (end_of_game_timer_start) begin
          running_d = 1'b1;
          timer_d   = TIMER_LOAD;
          state_d   = ST_SETTLE;
        end
      end

      // game_won is taken on the last running cycle, so a collision latched
      // by the game master while it shows its end screen still counts.
      ST_SETTLE: begin
        if (timer_q != 26'd0) begin
          timer_d = timer_q - 26'd1;
        end else begin
          running_d  = 1'b0;
          last_won_d = game_won;
          state_d    = ST_SCORE;
        end
      end

      ST_SCORE: begin
        round_count_d  = round_inc;
        score_wins_d   = wins_inc;
        score_losses_d = losses_inc;
        if (match_done) begin
          match_over_d = 1'b1;
          match_won_d  = (wins_inc >= WIN_LIMIT);
          hold_d       = 1'b1;
          state_d      = ST_MATCH_OVER;
        end else begin
          hold_d  = 1'b0;
          state_d = ST_PLAY;
        end
      end

      // The key stroke that leaves here only returns to IDLE; a second press
      // is needed to start, so it cannot also fire a torpedo.
      ST_MATCH_OVER: begin
        if (key_press) begin
          match_over_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        hold_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      key_prev_q     <= 1'b0;
      key_armed_q    <= 1'b0;
      timer_q        <= 26'd0;
      running_q      <= 1'b0;
      hold_q         <= 1'b1;
      round_count_q  <= 4'd0;
      score_wins_q   <= 4'd0;
      score_losses_q <= 4'd0;
      last_won_q     <= 1'b0;
      match_over_q   <= 1'b0;
      match_won_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_prev_q     <= key_prev_d;
      key_armed_q    <= key_armed_d;
      timer_q        <= timer_d;
      running_q      <= running_d;
      hold_q         <= hold_d;
      round_count_q  <= round_count_d;
      score_wins_q   <= score_wins_d;
      score_losses_q <= score_losses_d;
      last_won_q     <= last_won_d;
      match_over_q   <= match_over_d;
      match_won_q    <= match_won_d;
    end
  end

  assign end_of_game_timer_running = running_q;
  assign game_hold                 = hold_q;
  assign round_count               = round_count_q;
  assign score_wins                = score_wins_q;
  assign score_losses              = score_losses_q;
  assign last_round_won            = last_won_q;
  assign match_over                = match_over_q;
  assign match_won                 = match_won_q;

endmodule

// File: tb/tb_game_match_controller.sv
// tb_game_match_controller
//   Self-checking bench for game_match_controller with TIMER_CYCLES=4,
//   ROUNDS=5 and WIN_THRESHOLD=3. A behavioural match model tracks rounds,
//   timer time left and scores as plain integers. Every cycle the DUT
//   outputs are compared against it, and a few hand-derived literal
//   expectations pin the model.
module tb_game_match_controller;

  localparam int TIMER_CYCLES  = 4;
  localparam int ROUNDS        = 5;
  localparam int WIN_THRESHOLD = 3;

  logic       clk;
  logic       reset;
  logic       key;
  logic       end_of_game_timer_start;
  logic       game_won;
  logic       end_of_game_timer_running;
  logic       game_hold;
  logic [3:0] round_count;
  logic [3:0] score_wins;
  logic [3:0] score_losses;
  logic       last_round_won;
  logic       match_over;
  logic       match_won;

  int compared   = 0;
  int mismatched = 0;
  bit checkEnable = 0;

  game_match_controller #(
    .TIMER_CYCLES (TIMER_CYCLES),
    .ROUNDS       (ROUNDS),
    .WIN_THRESHOLD(WIN_THRESHOLD)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .key                      (key),
    .end_of_game_timer_start  (end_of_game_timer_start),
    .game_won                 (game_won),
    .end_of_game_timer_running(end_of_game_timer_running),
    .game_hold                (game_hold),
    .round_count              (round_count),
    .score_wins               (score_wins),
    .score_losses             (score_losses),
    .last_round_won           (last_round_won),
    .match_over               (match_over),
    .match_won                (match_won)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural match model. A key press is a rising edge of key after key
  // has been seen low since reset. The timer runs for TIMER_CYCLES cycles and
  // takes game_won on its last cycle. The round is scored one cycle later.
  bit mPrevKey, mKeyPress, mIdle, mOver, mPending, mLast, mHold;
  int mTimer, mRounds, mWins, mLosses, mWon;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mPrevKey = 1'b1;
      mIdle    = 1'b1;
      mOver    = 1'b0;
      mPending = 1'b0;
      mLast    = 1'b0;
      mHold    = 1'b1;
      mTimer   = 0;
      mRounds  = 0;
      mWins    = 0;
      mLosses  = 0;
      mWon     = 0;
    end else begin
      mKeyPress = key && !mPrevKey;
      mPrevKey  = key;
      if (mIdle) begin
        if (mKeyPress) begin
          mRounds = 0;
          mWins   = 0;
          mLosses = 0;
          mLast   = 1'b0;
          mWon    = 0;
          mHold   = 1'b0;
          mIdle   = 1'b0;
        end
      end else if (mOver) begin
        if (mKeyPress) begin
          mOver = 1'b0;
          mIdle = 1'b1;
        end
      end else if (mPending) begin
        mPending = 1'b0;
        mRounds++;
        if (mLast) mWins++;
        else mLosses++;
        if (mWins >= WIN_THRESHOLD || mLosses > ROUNDS - WIN_THRESHOLD ||
            mRounds >= ROUNDS) begin
          mOver = 1'b1;
          mWon  = (mWins >= WIN_THRESHOLD) ? 1 : 0;
          mHold = 1'b1;
        end
      end else if (mTimer > 0) begin
        mTimer--;
        if (mTimer == 0) begin
          mLast    = game_won;
          mPending = 1'b1;
        end
      end else if (end_of_game_timer_start) begin
        mTimer = TIMER_CYCLES;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (reset && checkEnable) begin
      checkOutput("running", int'(end_of_game_timer_running), (mTimer > 0) ? 1 : 0);
      checkOutput("game_hold", int'(game_hold), int'(mHold));
      checkOutput("round_count", int'(round_count), mRounds);
      checkOutput("score_wins", int'(score_wins), mWins);
      checkOutput("score_losses", int'(score_losses), mLosses);
      checkOutput("last_round_won", int'(last_round_won), int'(mLast));
      checkOutput("match_over", int'(match_over), int'(mOver));
      checkOutput("match_won", int'(match_won), mWon);
    end
  end

  // Drives one cycle of inputs; starts and ends at a falling edge.
  task automatic applyStimulus(input logic k, input logic s, input logic g);
    key                     = k;
    end_of_game_timer_start = s;
    game_won                = g;
    @(negedge clk);
  endtask

  task automatic pressKey();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  // One round: start pulse, then four cycles of game_won taken from
  // gwPattern[0..3] (bit 3 lands on the last running cycle), then the
  // scoring cycle. runCount counts cycles with running high.
  task automatic playRound(input logic [3:0] gwPattern, input bit randomStarts,
                           output int runCount);
    runCount = 0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (end_of_game_timer_running) runCount++;
      applyStimulus(1'b0,
                    randomStarts && ($urandom_range(0, 3) == 0),
                    (i < 4) ? gwPattern[i] : 1'($urandom_range(0, 1)));
    end
  endtask

  function automatic logic [3:0] roundPattern(input bit won);
    return {won, 3'($urandom_range(0, 7))};
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int runCount;
    bit seq[5];

    reset                   = 1'b0;
    key                     = 1'b1;
    end_of_game_timer_start = 1'b0;
    game_won                = 1'b0;
    repeat (3) @(negedge clk);
    reset       = 1'b1;
    checkEnable = 1'b1;

    checkOutput("reset_hold", int'(game_hold), 1);
    checkOutput("reset_running", int'(end_of_game_timer_running), 0);
    checkOutput("reset_rounds", int'(round_count), 0);
    checkOutput("reset_over", int'(match_over), 0);

    // Key held through reset release must not start a match.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("held_key_hold", int'(game_hold), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Key press releases the game master one cycle later.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("press_hold", int'(game_hold), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("press_running", int'(end_of_game_timer_running), 0);
    checkOutput("press_wins", int'(score_wins), 0);

    // game_won rises on running cycle 3 and is still high on the last one.
    playRound(4'b1100, 1'b0, runCount);
    checkOutput("r1_run_cycles", runCount, 4);
    checkOutput("r1_last_won", int'(last_round_won), 1);
    checkOutput("r1_wins", int'(score_wins), 1);
    checkOutput("r1_rounds", int'(round_count), 1);
    checkOutput("r1_hold", int'(game_hold), 0);

    // Three wins in a row end the match early.
    playRound(roundPattern(1'b1), 1'b1, runCount);
    playRound(roundPattern(1'b1), 1'b1, runCount);
    checkOutput("www_run_cycles", runCount, 4);
    checkOutput("www_over", int'(match_over), 1);
    checkOutput("www_won", int'(match_won), 1);
    checkOutput("www_hold", int'(game_hold), 1);
    checkOutput("www_rounds", int'(round_count), 3);
    checkOutput("www_losses", int'(score_losses), 0);

    // Start pulse in MATCH_OVER is ignored.
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("over_start_running", int'(end_of_game_timer_running), 0);
    checkOutput("over_start_rounds", int'(round_count), 3);

    // Key press leaves MATCH_OVER for IDLE; the game master stays held.
    pressKey();
    checkOutput("to_idle_over", int'(match_over), 0);
    checkOutput("to_idle_hold", int'(game_hold), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_start_running", int'(end_of_game_timer_running), 0);
    checkOutput("idle_start_rounds", int'(round_count), 3);
    pressKey();
    checkOutput("restart_rounds", int'(round_count), 0);
    checkOutput("restart_wins", int'(score_wins), 0);
    checkOutput("restart_hold", int'(game_hold), 0);

    // L,W,L,W,L runs the full five rounds and is lost.
    seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int r = 0; r < 5; r++) begin
      playRound(roundPattern(seq[r]), 1'b1, runCount);
    end
    checkOutput("lwlwl_over", int'(match_over), 1);
    checkOutput("lwlwl_losses", int'(score_losses), 3);
    checkOutput("lwlwl_wins", int'(score_wins), 2);
    checkOutput("lwlwl_rounds", int'(round_count), 5);
    checkOutput("lwlwl_won", int'(match_won), 0);
    pressKey();
    pressKey();

    // L,L,L ends after round 3.
    for (int r = 0; r < 3; r++) begin
      playRound(roundPattern(1'b0), 1'b1, runCount);
    end
    checkOutput("lll_over", int'(match_over), 1);
    checkOutput("lll_rounds", int'(round_count), 3);
    checkOutput("lll_won", int'(match_won), 0);
    pressKey();
    pressKey();

    // Random matches checked by the model every cycle.
    for (int m = 0; m < 8; m++) begin
      for (int r = 0; r < ROUNDS + 2 && !mOver; r++) begin
        playRound(roundPattern(1'($urandom_range(0, 1))), 1'b1, runCount);
      end
      checkOutput("random_match_ends", int'(match_over), 1);
      pressKey();
      pressKey();
    end

    // Reset asserted two cycles into the timer.
    playRound(roundPattern(1'b1), 1'b0, runCount);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_running", int'(end_of_game_timer_running), 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_running", int'(end_of_game_timer_running), 0);
    checkOutput("async_hold", int'(game_hold), 1);
    checkOutput("async_wins", int'(score_wins), 0);
    checkOutput("async_rounds", int'(round_count), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_running", int'(end_of_game_timer_running), 0);
    checkOutput("post_reset_hold", int'(game_hold), 1);
    pressKey();
    checkOutput("post_reset_release", int'(game_hold), 0);
    playRound(roundPattern(1'b0), 1'b0, runCount);
    checkOutput("post_reset_losses", int'(score_losses), 1);

    checkEnable = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
